// File: rtl/truth_table_scanner_if.sv
// Handshake and data bundle between the truth-table scanner and its host/function block.
// slave  : scanner side (takes start/abort/f_in, drives code, status and results).
// master : host side (drives start/abort and F, observes code, status and results).
interface truth_table_scanner_if #(
    parameter int unsigned N_IN = 5
) ();
    logic                 start;
    logic                 abort;
    logic                 f_in;
    logic [N_IN-1:0]      x_out;
    logic                 busy;
    logic                 done;
    logic                 pass;
    logic [(2**N_IN)-1:0] table_out;
    logic [N_IN:0]        err_count;
    logic [N_IN-1:0]      first_err_idx;
    logic                 first_err_valid;

    modport slave (
        input  start, abort, f_in,
        output x_out, busy, done, pass, table_out, err_count, first_err_idx, first_err_valid
    );

    modport master (
        output start, abort, f_in,
        input  x_out, busy, done, pass, table_out, err_count, first_err_idx, first_err_valid
    );
endinterface

// File: rtl/truth_table_scanner.sv
// Self-test sequencer for a combinational N_IN-input function block. On start it walks every
// input code, holds each for SETTLE cycles, samples F on the last cycle of the hold, records the
// truth table and compares it against EXPECTED.
// Ports:
//   clk  - rising-edge clock
//   rst  - synchronous active-high reset
//   bus  - truth_table_scanner_if.slave: start/abort/f_in in; x_out, busy, done, pass,
//          table_out, err_count, first_err_idx, first_err_valid out (all registered)
module truth_table_scanner #(
    parameter int unsigned          N_IN     = 5,
    parameter int unsigned          SETTLE   = 2,
    parameter logic [(2**N_IN)-1:0] EXPECTED = '0
) (
    input logic                  clk,
    input logic                  rst,
    truth_table_scanner_if.slave bus
);
    localparam logic [3:0]      SettleLast = 4'(SETTLE - 1);
    localparam logic [N_IN-1:0] LastIdx    = {N_IN{1'b1}};
    localparam logic [N_IN-1:0] IdxOne     = {{(N_IN-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {StIdle, StScan, StDone} state_e;

    state_e               state_q;
    logic [N_IN-1:0]      idx_q;
    logic [3:0]           cnt_q;
    logic [N_IN-1:0]      x_out_q;
    logic                 busy_q;
    logic                 done_q;
    logic                 pass_q;
    logic [(2**N_IN)-1:0] table_q;
    logic [N_IN:0]        err_q;
    logic [N_IN-1:0]      first_idx_q;
    logic                 first_valid_q;

    logic          sample_now;
    logic          mismatch;
    logic [N_IN:0] err_d;

    always_comb begin
        sample_now = (cnt_q == SettleLast);
        mismatch   = bus.f_in ^ EXPECTED[idx_q];
        // Count including the current sample so pass reflects the final code too.
        err_d      = err_q + {{N_IN{1'b0}}, mismatch};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= StIdle;
            idx_q         <= '0;
            cnt_q         <= '0;
            x_out_q       <= '0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            pass_q        <= 1'b0;
            table_q       <= '0;
            err_q         <= '0;
            first_idx_q   <= '0;
            first_valid_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (bus.start) begin
                        state_q       <= StScan;
                        idx_q         <= '0;
                        cnt_q         <= '0;
                        x_out_q       <= '0;
                        busy_q        <= 1'b1;
                        table_q       <= '0;
                        err_q         <= '0;
                        first_valid_q <= 1'b0;
                        pass_q        <= 1'b0;
                    end
                end
                StScan: begin
                    if (bus.abort) begin
                        // Partial results are kept; no sample on this edge.
                        state_q <= StIdle;
                        x_out_q <= '0;
                        busy_q  <= 1'b0;
                        pass_q  <= 1'b0;
                    end else if (sample_now) begin
                        table_q[idx_q] <= bus.f_in;
                        err_q          <= err_d;
                        if (mismatch && !first_valid_q) begin
                            first_idx_q   <= idx_q;
                            first_valid_q <= 1'b1;
                        end
                        if (idx_q == LastIdx) begin
                            state_q <= StDone;
                            x_out_q <= '0;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            pass_q  <= (err_d == '0);
                        end else begin
                            idx_q   <= idx_q + IdxOne;
                            x_out_q <= idx_q + IdxOne;
                            cnt_q   <= '0;
                        end
                    end else begin
                        cnt_q <= cnt_q + 4'd1;
                    end
                end
                StDone: begin
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign bus.x_out           = x_out_q;
    assign bus.busy            = busy_q;
    assign bus.done            = done_q;
    assign bus.pass            = pass_q;
    assign bus.table_out       = table_q;
    assign bus.err_count       = err_q;
    assign bus.first_err_idx   = first_idx_q;
    assign bus.first_err_valid = first_valid_q;
endmodule
